// File: rtl/yoda_ced_pkg.sv
// yoda_ced_pkg: shared pixel width, sequencer states and image defaults for the edge pipeline
package yoda_ced_pkg;
   localparam int PIX_W        = 8;
   localparam int DEF_FILT_LAT = 3;
   localparam int DEF_IMG_W    = 64;
   localparam int DEF_IMG_H    = 64;

   typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_STREAM, ST_DRAIN, ST_DONE} seq_state_t;

   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction
endpackage

// File: rtl/smoothing_sequencer_if.sv
// smoothing_sequencer_if: upstream pixel stream and downstream tagged-pixel strobe
interface smoothing_sequencer_if import yoda_ced_pkg::*; #(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H
);
   localparam int CW = clog2_min1(IMG_W);
   localparam int RW = clog2_min1(IMG_H);
   logic             in_valid;
   logic             in_ready;
   logic [PIX_W-1:0] pixel_in;
   logic             out_ready;
   logic             out_valid;
   logic [PIX_W-1:0] out_pixel;
   logic [CW-1:0]    out_col;
   logic [RW-1:0]    out_row;

   modport slave (
      input  in_valid, pixel_in, out_ready,
      output in_ready, out_valid, out_pixel, out_col, out_row
   );
   modport master (
      output in_valid, pixel_in, out_ready,
      input  in_ready, out_valid, out_pixel, out_col, out_row
   );
endinterface

// File: rtl/valid_tag_pipe.sv
// valid_tag_pipe: enabled shift register marking which filter slots hold real pixels
module valid_tag_pipe #(
   parameter int DEPTH = 3
) (
   input  logic clk,
   input  logic i_clr,
   input  logic i_en,
   input  logic i_d,
   output logic o_q
);
   logic [DEPTH-1:0] r_tag;

   // shift a tag in on every enabled cycle; clear wipes all slots
   always_ff @(posedge clk)
      if (i_clr) r_tag <= '0;
      else if (i_en) r_tag <= DEPTH'({r_tag, i_d});

   assign o_q = r_tag[DEPTH-1];
endmodule

// File: rtl/smoothing_sequencer.sv
// smoothing_sequencer: frame controller feeding the smoothing filter and tagging its output pixels
module smoothing_sequencer import yoda_ced_pkg::*; #(
   parameter int IMG_W    = DEF_IMG_W,
   parameter int IMG_H    = DEF_IMG_H,
   parameter int FILT_LAT = DEF_FILT_LAT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             filt_enb,
   output logic             filt_reset,
   output logic [PIX_W-1:0] filt_data,
   input  logic [PIX_W-1:0] filt_result,
   smoothing_sequencer_if.slave s
);
   localparam int TOTAL = IMG_W * IMG_H;
   localparam int NW    = $clog2(TOTAL + 1);
   localparam int CW    = clog2_min1(IMG_W);
   localparam int RW    = clog2_min1(IMG_H);

   seq_state_t     r_state;
   logic [NW-1:0]  r_issued;
   logic [NW-1:0]  r_retired;
   logic [CW-1:0]  r_col;
   logic [RW-1:0]  r_row;
   logic           w_stream;
   logic           w_drain;
   logic           w_issue;
   logic           w_tag;
   logic           w_col_wrap;

   assign w_stream    = r_state == ST_STREAM;
   assign w_drain     = r_state == ST_DRAIN;
   assign s.in_ready  = w_stream && s.out_ready && (r_issued < NW'(TOTAL));
   assign w_issue     = s.in_valid && s.in_ready;
   assign filt_enb    = w_issue || (w_drain && s.out_ready);
   assign filt_data   = w_issue ? s.pixel_in : '0;
   assign filt_reset  = reset || (r_state == ST_CLEAR);
   assign busy        = r_state != ST_IDLE;
   assign done        = r_state == ST_DONE;
   assign s.out_valid = w_tag && filt_enb;
   assign s.out_pixel = filt_result;
   assign s.out_col   = r_col;
   assign s.out_row   = r_row;
   assign w_col_wrap  = r_col == CW'(IMG_W - 1);

   // tags enter as 1 while streaming real pixels and as 0 while flushing
   valid_tag_pipe #(.DEPTH(FILT_LAT)) u_tags (
      .clk  (clk),
      .i_clr(filt_reset),
      .i_en (filt_enb),
      .i_d  (w_stream),
      .o_q  (w_tag)
   );

   // frame FSM with issue/retire counters and output coordinate tracking
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_issued  <= '0;
         r_retired <= '0;
         r_col     <= '0;
         r_row     <= '0;
      end else begin
         if (w_issue) r_issued <= r_issued + NW'(1);
         if (s.out_valid) begin
            r_retired <= r_retired + NW'(1);
            r_col     <= w_col_wrap ? '0 : r_col + CW'(1);
            r_row     <= !w_col_wrap ? r_row : (r_row == RW'(IMG_H - 1)) ? '0 : r_row + RW'(1);
         end
         case (r_state)
            ST_IDLE:   if (start) r_state <= ST_CLEAR;
            ST_CLEAR: begin
               r_state   <= ST_STREAM;
               r_issued  <= '0;
               r_retired <= '0;
               r_col     <= '0;
               r_row     <= '0;
            end
            ST_STREAM: if (w_issue && r_issued == NW'(TOTAL - 1)) r_state <= ST_DRAIN;
            ST_DRAIN:  if (s.out_valid && r_retired == NW'(TOTAL - 1)) r_state <= ST_DONE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_smoothing_sequencer.sv
// tb_smoothing_sequencer: randomized frames scored against an in-order pixel/coordinate reference
module tb_smoothing_sequencer;
   import yoda_ced_pkg::*;
   localparam int W = 4;
   localparam int H = 2;
   localparam int L = 3;
   localparam int N = W * H;

   typedef struct {
      logic [7:0] p;
      int         c;
      int         r;
   } exp_t;

   logic       clk = 0;
   logic       reset = 1;
   logic       start = 0;
   logic       busy, done, filt_enb, filt_reset;
   logic [7:0] filt_data, filt_result;
   logic [7:0] fm [3];

   exp_t q[$];
   int checks = 0, errors = 0, cyc = 0;
   int n_iss = 0, n_str = 0, f_enb = 0, f_done = 0, f_frst = 0, last_str = 0;

   smoothing_sequencer_if #(.IMG_W(W), .IMG_H(H)) s ();

   smoothing_sequencer #(.IMG_W(W), .IMG_H(H), .FILT_LAT(L)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .filt_enb   (filt_enb),
      .filt_reset (filt_reset),
      .filt_data  (filt_data),
      .filt_result(filt_result),
      .s          (s)
   );

   always #5 clk = ~clk;

   // filter stand-in: plain three-enabled-cycle delay line
   always @(posedge clk)
      if (filt_reset) begin
         fm[0] <= 0; fm[1] <= 0; fm[2] <= 0;
      end else if (filt_enb) begin
         fm[0] <= filt_data; fm[1] <= fm[0]; fm[2] <= fm[1];
      end
   assign filt_result = fm[2];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // monitor: scoreboard pushes on accepted pixels, pops on each output strobe
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (reset) begin
         q.delete();
         n_iss = 0;
         n_str = 0;
      end else begin
         if (filt_reset) f_frst++;
         if (!s.out_ready) begin
            chk("stall_enb", filt_enb, 0);
            chk("stall_in_ready", s.in_ready, 0);
            chk("stall_out_valid", s.out_valid, 0);
         end
         if (busy && n_iss < N && !s.in_valid) begin
            chk("gap_enb", filt_enb, 0);
            chk("gap_out_valid", s.out_valid, 0);
         end
         if (s.in_valid && s.in_ready) begin
            chk("issue_enb", filt_enb, 1);
            chk("issue_data", filt_data, s.pixel_in);
            q.push_back('{s.pixel_in, n_iss % W, n_iss / W});
            n_iss++;
         end
         if (filt_enb) f_enb++;
         if (s.out_valid) begin
            n_str++;
            last_str = cyc;
            if (n_str == 1) chk("first_strobe_enb", f_enb, L + 1);
            if (q.size() == 0) chk("strobe_expected", q.size(), 1);
            else begin
               e = q.pop_front();
               chk("out_pixel", s.out_pixel, e.p);
               chk("out_col", s.out_col, e.c);
               chk("out_row", s.out_row, e.r);
            end
         end
         if (done) begin
            f_done++;
            chk("done_after_last", cyc - last_str, 1);
            chk("done_strobes", n_str, N);
         end
      end
   end

   task automatic clear_stats();
      n_iss = 0; n_str = 0; f_enb = 0; f_done = 0; f_frst = 0;
   endtask

   task automatic run_frame(input bit bub, input bit stl, input bit rnd, input bit ign);
      int t = 0, left = 0;
      bit us = 0, ud = 0;
      clear_stats();
      @(posedge clk); #1;
      start = 1; s.in_valid = 0; s.out_ready = 1;
      @(negedge clk);
      chk("busy_at_start", busy, 0);
      @(posedge clk); #1;
      start = 0;
      @(negedge clk);
      chk("busy_clear", busy, 1);
      chk("filt_reset_clear", filt_reset, 1);
      chk("in_ready_clear", s.in_ready, 0);
      while (t < 300) begin
         @(posedge clk); #1;
         t++;
         if (done) begin
            start = ign;
            s.in_valid = 0;
            break;
         end
         s.pixel_in = 8'($urandom);
         s.in_valid = bub ? (t % 3 == 1) : rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stl && !us && n_iss == 3) begin us = 1; left = 5; end
         if (stl && !ud && n_iss == N && n_str == 5) begin ud = 1; left = 2; end
         s.out_ready = rnd ? ($urandom_range(0, 3) != 0) : (left == 0);
         if (left > 0) left--;
         start = ign && t == 4;
      end
      if (t >= 300) chk("frame_timeout", t, 0);
      @(posedge clk); #1;
      start = 0; s.out_ready = 1;
      @(negedge clk);
      chk("idle_after_done", busy, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("no_restart", busy, 0);
      chk("enb_total", f_enb, N + L);
      chk("strobe_total", n_str, N);
      chk("done_pulses", f_done, 1);
      chk("filt_reset_pulses", f_frst, 1);
      chk("scoreboard_empty", q.size(), 0);
   endtask

   task automatic mid_reset();
      int t = 0;
      clear_stats();
      @(posedge clk); #1;
      start = 1; s.in_valid = 1; s.out_ready = 1;
      @(posedge clk); #1;
      start = 0;
      while (n_iss < 5 && t < 100) begin
         @(posedge clk); #1;
         t++;
         s.pixel_in = 8'($urandom);
      end
      if (t >= 100) chk("mid_timeout", t, 0);
      reset = 1;
      @(negedge clk);
      chk("mid_filt_reset", filt_reset, 1);
      @(posedge clk); #1;
      reset = 0; s.in_valid = 0;
      @(negedge clk);
      chk("mid_idle", busy, 0);
      chk("mid_out_valid", s.out_valid, 0);
      repeat (5) @(negedge clk);
      chk("mid_no_done", f_done, 0);
      chk("mid_still_idle", busy, 0);
   endtask

   initial begin
      s.in_valid = 0; s.pixel_in = 0; s.out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         start = 1'($urandom); s.in_valid = 1'($urandom);
         s.pixel_in = 8'($urandom); s.out_ready = 1'($urandom);
         @(negedge clk);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_in_ready", s.in_ready, 0);
         chk("rst_enb", filt_enb, 0);
         chk("rst_data", filt_data, 0);
         chk("rst_out_valid", s.out_valid, 0);
         chk("rst_col", s.out_col, 0);
         chk("rst_row", s.out_row, 0);
         chk("rst_filt_reset", filt_reset, 1);
      end
      @(posedge clk); #1;
      reset = 0; start = 0; s.in_valid = 0; s.out_ready = 1;
      run_frame(0, 0, 0, 0);
      run_frame(1, 0, 0, 0);
      run_frame(0, 1, 0, 0);
      mid_reset();
      run_frame(0, 0, 0, 0);
      run_frame(0, 0, 0, 1);
      repeat (3) run_frame(0, 0, 1, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/smoothing_sequencer.md
# smoothing_sequencer

Frame-level controller for the Gaussian smoothing stage of the edge-detection pipeline. Accepts a raster stream of 8-bit pixels from the image source over a valid/ready handshake. Drives the smoothing filter's enable, reset and data inputs, and tracks the filter's fixed latency with a tag pipeline. Flushes the filter at end of frame and emits each smoothed pixel as a strobe tagged with its column/row for the gradient stage.

## Interface
- `IMG_W`, 64: pixels per row (≥2)
- `IMG_H`, 64: rows per frame (≥1)
- `FILT_LAT`, 3: filter latency in enabled cycles (≥1)
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a frame; sampled only in IDLE
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after last output pixel
- `in_valid`  in  1  upstream pixel valid
- `in_ready`  out  1  sequencer accepts pixel this cycle
- `pixel_in`  in  8  upstream pixel
- `filt_enb`  out  1  filter advance enable
- `filt_reset`  out  1  filter clear
- `filt_data`  out  8  pixel to filter
- `filt_result`  in  8  filter output
- `out_ready`  in  1  downstream stall; low freezes filter and input
- `out_valid`  out  1  one-cycle strobe; output pixel present
- `out_pixel`  out  8  equals `filt_result`
- `out_col`  out  clog2(IMG_W)  column of output pixel
- `out_row`  out  clog2(IMG_H)  row of output pixel

## Operation
- States: IDLE → CLEAR → STREAM → DRAIN → DONE → IDLE.
- IDLE: `start`=1 → CLEAR. Otherwise stay.
- CLEAR: exactly one cycle. `filt_reset`=1, tag pipeline and all counters zeroed → STREAM.
- STREAM:
  - `in_ready` = `out_ready` && (issued < IMG_W*IMG_H).
  - Issue = `in_valid` && `in_ready`. On issue: `filt_enb`=1, `filt_data`=`pixel_in`, tag 1 shifted in, issued++.
  - No issue → `filt_enb`=0; the filter never sees bubbles.
  - issued reaches total on an issue edge → DRAIN.
- DRAIN:
  - `filt_enb` = `out_ready`, `filt_data`=0, tag 0 shifted in.
  - `in_ready`=0.
  - When retired reaches total → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- Tag pipeline: FILT_LAT bits, shifts only on `filt_enb`.
- Outputs: `out_valid` = tag[FILT_LAT-1] && `filt_enb`. Each `out_valid` increments retired and advances col/row. col wraps at IMG_W-1 to 0 and increments row.
- `out_col`/`out_row` hold the coordinates of the pixel currently presented.
- `filt_reset` = `reset` || (state==CLEAR).
- Counters are clog2(IMG_W*IMG_H+1) bits wide. No saturation is needed; bounds are guarded by state.
- `start` while busy is ignored. `start` in the DONE cycle is ignored; it must be reasserted in IDLE.
- `reset` mid-frame: the next state is IDLE, all counters and tags clear, and the filter is cleared via `filt_reset`. No `done` is issued.

## Timing
- Reset values: `busy`=0, `done`=0, `in_ready`=0, `filt_enb`=0, `filt_data`=0, `out_valid`=0, `out_col`=0, `out_row`=0. `filt_reset`=1 while `reset` is high.
- Start to first `in_ready`: `start` seen in cycle t, CLEAR in t+1, STREAM from t+2.
- Latency: a pixel issued on enabled cycle k is output on enabled cycle k+FILT_LAT.
- With no stalls, a frame takes IMG_W*IMG_H+FILT_LAT enabled cycles. `done` asserts the cycle after the last `out_valid`.
- `in_ready`, `filt_enb` and `out_valid` are combinational from state, counters, `in_valid` and `out_ready`. All state is registered.
- `out_ready` low: `filt_enb`=0 and `in_ready`=0 in the same cycle; no output strobe.

## Structure
- Shared package `yoda_ced_pkg` holds:
  - pixel width (8)
  - sequencer state encoding (IDLE/CLEAR/STREAM/DRAIN/DONE)
  - default FILT_LAT
  - image dimension defaults
- One sub-module `valid_tag_pipe`: parameterised-depth shift register with shift enable and synchronous clear. It is reused later by the gradient and non-max stages.
- The FSM, counters and coordinate tracking stay in `smoothing_sequencer`.

## Test plan
Use IMG_W=4, IMG_H=2, FILT_LAT=3 with a filter model delaying by 3 enabled cycles.
- Reset: hold `reset` 3 cycles with random inputs → all outputs at reset values, `filt_reset`=1, `busy`=0.
- Streaming, no stalls: `start`, `in_valid`=1 continuously, `out_ready`=1.
  - `busy` from the cycle after `start`, `filt_reset` pulsed once.
  - 11 `filt_enb` cycles total; first `out_valid` on the 4th.
  - 8 strobes with (col,row) = (0,0)…(3,0),(0,1)…(3,1).
  - `done` one cycle after the 8th strobe, then IDLE.
- Input bubbles: `in_valid` toggling 1,0,0,1…
  - `filt_enb`=0 in every gap, no `out_valid` in gaps.
  - Output sequence and coordinates identical to the no-stall case.
- Output stall: `out_ready`=0 for 5 cycles mid-STREAM and 2 cycles mid-DRAIN.
  - `in_ready`=0 and `filt_enb`=0 throughout each stall.
  - No pixel lost or duplicated; order preserved.
- Reset mid-frame: assert `reset` after 5 issues.
  - IDLE next cycle, no `done`.
  - Restart with `start` → clean 8-pixel frame from (0,0).
- Ignored start: pulse `start` during STREAM and during DONE → no effect on counts, no second frame begins.
